// File: rtl/rrns_pkg.sv
`default_nettype none
// ============================================================================
// Module : rrns_pkg
// Brief  : Shared RRNS constants: moduli, residue field positions, MRC terms.
// Rev    : 1.0  initial release
// ============================================================================
package rrns_pkg;

   // Non-redundant moduli
   localparam logic [6:0]  C_MOD_64 = 7'd64;
   localparam logic [6:0]  C_MOD_63 = 7'd63;
   localparam logic [6:0]  C_MOD_65 = 7'd65;

   // Redundant moduli
   localparam logic [4:0]  C_MOD_31 = 5'd31;
   localparam logic [4:0]  C_MOD_29 = 5'd29;
   localparam logic [4:0]  C_MOD_23 = 5'd23;
   localparam logic [4:0]  C_MOD_19 = 5'd19;
   localparam logic [4:0]  C_MOD_17 = 5'd17;

   // Residue field LSB positions in the packed 64-bit word (shared with encoder_3nrm)
   localparam int          C_R64_LSB    = 58;
   localparam int          C_R63_LSB    = 52;
   localparam int          C_R65_LSB    = 45;
   localparam int          C_R31_LSB    = 40;
   localparam int          C_R29_LSB    = 35;
   localparam int          C_R23_LSB    = 30;
   localparam int          C_R19_LSB    = 25;
   localparam int          C_R17_LSB    = 20;
   localparam int          C_FIELD_BASE = 20;

   // Modular inverses used by the mixed-radix conversion
   localparam logic [6:0]  C_INV64_MOD63 = 7'd1;
   localparam logic [6:0]  C_INV64_MOD65 = 7'd64;
   localparam logic [6:0]  C_INV63_MOD65 = 7'd32;

   // Mixed-radix weights and legal output range
   localparam logic [17:0] C_W1    = 18'd64;
   localparam logic [17:0] C_W2    = 18'd4032;
   localparam logic [17:0] C_X_MAX = 18'd65535;

   // FSM state encoding
   localparam logic [2:0]  ST_IDLE  = 3'd0;
   localparam logic [2:0]  ST_MRC1  = 3'd1;
   localparam logic [2:0]  ST_MRC2  = 3'd2;
   localparam logic [2:0]  ST_RECON = 3'd3;
   localparam logic [2:0]  ST_CHK   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/rrns_mod_const.sv
`default_nettype none
// ============================================================================
// Module : rrns_mod_const
// Brief  : X mod m for the five redundant moduli, selected by index (comb).
// Rev    : 1.0  initial release
// ============================================================================
module rrns_mod_const
   import rrns_pkg::*;
(
   input  logic [17:0] x_i,
   input  logic [2:0]  sel_i,
   output logic [4:0]  res_o
);

   // Each branch divides by a constant so synthesis builds a fixed reducer.
   always_comb begin
      res_o = 5'd0;
      case (sel_i)
         3'd0:    res_o = 5'(x_i % 18'(C_MOD_31));
         3'd1:    res_o = 5'(x_i % 18'(C_MOD_29));
         3'd2:    res_o = 5'(x_i % 18'(C_MOD_23));
         3'd3:    res_o = 5'(x_i % 18'(C_MOD_19));
         3'd4:    res_o = 5'(x_i % 18'(C_MOD_17));
         default: res_o = 5'd0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/decoder_3nrm.sv
`default_nettype none
// ============================================================================
// Module : decoder_3nrm
// Brief  : 3NRM RRNS decoder: MRC reconstruction over 64/63/65 plus detection.
// Rev    : 1.0  initial release
// ============================================================================
module decoder_3nrm
   import rrns_pkg::*;
#(
   parameter int CHECK_EN = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [63:0] residues_in,
   output logic [15:0] data_out,
   output logic        err,
   output logic [5:0]  err_mask,
   output logic        busy,
   output logic        done
);

   logic [2:0]  state_q, state_d;
   logic [43:0] res_q, res_d;
   logic [5:0]  a1_q, a1_d;
   logic [5:0]  a2_q, a2_d;
   logic [6:0]  t_q, t_d;
   logic [6:0]  a3_q, a3_d;
   logic [17:0] x_q, x_d;
   logic [2:0]  idx_q, idx_d;
   logic [5:0]  mask_q, mask_d;
   logic [15:0] data_q, data_d;
   logic [5:0]  emask_q, emask_d;
   logic        err_q, err_d;
   logic        done_q, done_d;

   logic        unused_low;
   assign unused_low = ^residues_in[C_FIELD_BASE-1:0];

   logic [5:0]  r64, r63, r63m, a1, a1m;
   logic [6:0]  r65, r65m, diff63, t_new, a3_new;
   logic [7:0]  diff65, diff_t;
   logic [17:0] x_new;

   assign r64 = res_q[C_R64_LSB-C_FIELD_BASE +: 6];
   assign r63 = res_q[C_R63_LSB-C_FIELD_BASE +: 6];
   assign r65 = res_q[C_R65_LSB-C_FIELD_BASE +: 7];

   // MRC step 1: every difference is folded back into [0, m-1] before scaling
   assign a1     = 6'(7'(r64) % C_MOD_64);
   assign r63m   = (r63 == 6'(C_MOD_63)) ? 6'd0 : r63;
   assign a1m    = (a1  == 6'(C_MOD_63)) ? 6'd0 : a1;
   assign diff63 = (r63m >= a1m) ? 7'(r63m - a1m) : 7'(r63m) + C_MOD_63 - 7'(a1m);
   assign a2_d   = (state_q == ST_MRC1)
                 ? 6'((14'(diff63) * 14'(C_INV64_MOD63)) % 14'(C_MOD_63)) : a2_q;
   assign r65m   = (r65 >= C_MOD_65) ? r65 - C_MOD_65 : r65;
   assign diff65 = (r65m >= 7'(a1)) ? 8'(r65m - 7'(a1))
                                    : 8'(r65m) + 8'(C_MOD_65) - 8'(a1);
   // (r65 - a1) * 64 == (a1 - r65) mod 65
   assign t_new  = 7'((14'(diff65) * 14'(C_INV64_MOD65)) % 14'(C_MOD_65));

   assign diff_t = (t_q >= 7'(a2_q)) ? 8'(t_q - 7'(a2_q))
                                     : 8'(t_q) + 8'(C_MOD_65) - 8'(a2_q);
   assign a3_new = 7'((14'(diff_t) * 14'(C_INV63_MOD65)) % 14'(C_MOD_65));

   assign x_new  = 18'(a1_q) + 18'(a2_q) * C_W1 + 18'(a3_q) * C_W2;

   logic [4:0] rem, rx;
   logic [5:0] bit_sel, mask_chk;

   rrns_mod_const u_mod (
      .x_i   (x_q),
      .sel_i (idx_q),
      .res_o (rem)
   );

   always_comb begin
      rx      = 5'd0;
      bit_sel = 6'b000000;
      case (idx_q)
         3'd0:    begin rx = res_q[C_R31_LSB-C_FIELD_BASE +: 5]; bit_sel = 6'b010000; end
         3'd1:    begin rx = res_q[C_R29_LSB-C_FIELD_BASE +: 5]; bit_sel = 6'b001000; end
         3'd2:    begin rx = res_q[C_R23_LSB-C_FIELD_BASE +: 5]; bit_sel = 6'b000100; end
         3'd3:    begin rx = res_q[C_R19_LSB-C_FIELD_BASE +: 5]; bit_sel = 6'b000010; end
         3'd4:    begin rx = res_q[C_R17_LSB-C_FIELD_BASE +: 5]; bit_sel = 6'b000001; end
         default: begin rx = 5'd0; bit_sel = 6'b000000; end
      endcase
   end

   // An out-of-range received residue can never equal rem, so it flags by itself.
   assign mask_chk = mask_q | ((rem != rx) ? bit_sel : 6'b000000);

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      a1_d    = a1_q;
      t_d     = t_q;
      a3_d    = a3_q;
      x_d     = x_q;
      idx_d   = idx_q;
      mask_d  = mask_q;
      data_d  = data_q;
      emask_d = emask_q;
      err_d   = err_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               res_d   = residues_in[63:C_FIELD_BASE];
               state_d = ST_MRC1;
            end
         end
         ST_MRC1: begin
            a1_d    = a1;
            t_d     = t_new;
            state_d = ST_MRC2;
         end
         ST_MRC2: begin
            a3_d    = a3_new;
            state_d = ST_RECON;
         end
         ST_RECON: begin
            x_d    = x_new;
            mask_d = {(x_new > C_X_MAX), 5'b00000};
            idx_d  = 3'd0;
            if (CHECK_EN != 0) begin
               state_d = ST_CHK;
            end else begin
               state_d = ST_IDLE;
               data_d  = x_new[15:0];
               emask_d = {(x_new > C_X_MAX), 5'b00000};
               err_d   = (x_new > C_X_MAX);
               done_d  = 1'b1;
            end
         end
         ST_CHK: begin
            mask_d = mask_chk;
            if (idx_q == 3'd4) begin
               state_d = ST_IDLE;
               data_d  = x_q[15:0];
               emask_d = mask_chk;
               err_d   = |mask_chk;
               done_d  = 1'b1;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         res_q   <= '0;
         a1_q    <= '0;
         a2_q    <= '0;
         t_q     <= '0;
         a3_q    <= '0;
         x_q     <= '0;
         idx_q   <= '0;
         mask_q  <= '0;
         data_q  <= '0;
         emask_q <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         a1_q    <= a1_d;
         a2_q    <= a2_d;
         t_q     <= t_d;
         a3_q    <= a3_d;
         x_q     <= x_d;
         idx_q   <= idx_d;
         mask_q  <= mask_d;
         data_q  <= data_d;
         emask_q <= emask_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign data_out = data_q;
   assign err_mask = emask_q;
   assign err      = err_q;
   assign done     = done_q;
   assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_decoder_3nrm.sv
`default_nettype none
// ============================================================================
// Module : tb_decoder_3nrm
// Brief  : Scoreboard bench for decoder_3nrm (CHECK_EN=1 and CHECK_EN=0 builds).
// Rev    : 1.0  initial release
// ============================================================================
module tb_decoder_3nrm;

   typedef struct {
      logic [15:0] data;
      logic [5:0]  mask;
      int          due;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start1, start2;
   logic [63:0] res1, res2;
   logic [15:0] data1, data2;
   logic        err1, err2, busy1, busy2, done1, done2;
   logic [5:0]  mask1, mask2;

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   done_cnt1 = 0;
   int   done_cnt2 = 0;
   exp_t q1[$];
   exp_t q2[$];
   exp_t e1, e2;

   decoder_3nrm #(.CHECK_EN(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .residues_in(res1),
      .data_out(data1), .err(err1), .err_mask(mask1), .busy(busy1), .done(done1)
   );

   decoder_3nrm #(.CHECK_EN(0)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .residues_in(res2),
      .data_out(data2), .err(err2), .err_mask(mask2), .busy(busy2), .done(done2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && done1) begin
         done_cnt1++;
         if (q1.size() == 0) begin
            check("dut1_spurious_done", 1, 0);
         end else begin
            e1 = q1.pop_front();
            check("dut1_latency", cyc, e1.due);
            check("dut1_data", int'(data1), int'(e1.data));
            check("dut1_mask", int'(mask1), int'(e1.mask));
            check("dut1_err", int'(err1), int'(|e1.mask));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && done2) begin
         done_cnt2++;
         if (q2.size() == 0) begin
            check("dut2_spurious_done", 1, 0);
         end else begin
            e2 = q2.pop_front();
            check("dut2_latency", cyc, e2.due);
            check("dut2_data", int'(data2), int'(e2.data));
            check("dut2_mask", int'(mask2), int'(e2.mask));
            check("dut2_err", int'(err2), int'(|e2.mask));
         end
      end
   end

   function automatic logic [63:0] pack(input int r64, input int r63, input int r65,
                                        input int r31, input int r29, input int r23,
                                        input int r19, input int r17);
      logic [63:0] w;
      w        = '0;
      w[63:58] = 6'(r64);
      w[57:52] = 6'(r63);
      w[51:45] = 7'(r65);
      w[44:40] = 5'(r31);
      w[39:35] = 5'(r29);
      w[34:30] = 5'(r23);
      w[29:25] = 5'(r19);
      w[24:20] = 5'(r17);
      return w;
   endfunction

   function automatic logic [63:0] encode(input int x);
      logic [63:0] w;
      w        = pack(x % 64, x % 63, x % 65, x % 31, x % 29, x % 23, x % 19, x % 17);
      w[19:0]  = 20'($urandom);
      return w;
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic send1(input logic [63:0] w, input int d, input logic [5:0] m, input bit push);
      exp_t e;
      start1 = 1'b1;
      res1   = w;
      if (push) begin
         e.data = 16'(d);
         e.mask = m;
         e.due  = cyc + 9;
         q1.push_back(e);
      end
      step(1);
      start1 = 1'b0;
   endtask

   task automatic send2(input logic [63:0] w, input int d, input logic [5:0] m);
      exp_t e;
      start2 = 1'b1;
      res2   = w;
      e.data = 16'(d);
      e.mask = m;
      e.due  = cyc + 4;
      q2.push_back(e);
      step(1);
      start2 = 1'b0;
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while ((q1.size() != 0 || q2.size() != 0) && budget < 300) begin
         step(1);
         budget++;
      end
      check("drain_q1_empty", q1.size(), 0);
      check("drain_q2_empty", q2.size(), 0);
      q1.delete();
      q2.delete();
   endtask

   initial begin
      int x;
      int cnt_before;
      logic [63:0] w;
      rst_n  = 1'b0;
      start1 = 1'b0;
      start2 = 1'b0;
      res1   = '0;
      res2   = '0;
      step(3);
      check("reset_data", int'(data1), 0);
      check("reset_err", int'(err1), 0);
      check("reset_mask", int'(mask1), 0);
      check("reset_busy", int'(busy1), 0);
      check("reset_done", int'(done1), 0);
      rst_n = 1'b1;
      step(2);

      // Zero word
      send1(64'd0, 0, 6'b000000, 1'b1);
      check("busy_after_start", int'(busy1), 1);
      drain();

      // 65535
      send1(pack(63, 15, 15, 1, 24, 8, 4, 0), 65535, 6'b000000, 1'b1);
      drain();

      // 12345 with r31 corrupted from 7 to 8
      send1(pack(57, 60, 60, 8, 20, 17, 14, 3), 12345, 6'b010000, 1'b1);
      drain();

      // X = 133056: out of range, and every redundant residue disagrees
      send1(pack(0, 0, 1, 0, 0, 0, 0, 0), 1984, 6'b111111, 1'b1);
      drain();

      // Back-to-back: A, ignored mid-busy start, B in A's done cycle
      cnt_before = done_cnt1;
      send1(encode(1000), 1000, 6'b000000, 1'b1);
      step(2);
      send1(encode(4242), 0, 6'b000000, 1'b0);
      step(5);
      send1(encode(54321), 54321, 6'b000000, 1'b1);
      drain();
      step(3);
      check("b2b_done_count", done_cnt1 - cnt_before, 2);

      // Reset asserted while the word is in the CHK2 cycle
      cnt_before = done_cnt1;
      send1(encode(777), 0, 6'b000000, 1'b0);
      step(5);
      rst_n = 1'b0;
      #1;
      check("abort_data", int'(data1), 0);
      check("abort_mask", int'(mask1), 0);
      check("abort_busy", int'(busy1), 0);
      step(2);
      rst_n = 1'b1;
      step(15);
      check("abort_no_done", done_cnt1 - cnt_before, 0);
      check("abort_data_hold", int'(data1), 0);
      check("abort_err_hold", int'(err1), 0);

      // 100 random encoder words, one every 9 cycles
      for (int i = 0; i < 100; i++) begin
         x = int'($urandom_range(0, 65535));
         send1(encode(x), x, 6'b000000, 1'b1);
         step(8);
      end
      drain();

      // CHECK_EN=0 build: 4-cycle latency, redundant checks skipped
      send2(pack(0, 0, 1, 0, 0, 0, 0, 0), 1984, 6'b100000);
      step(3);
      send2(pack(57, 60, 60, 8, 20, 17, 14, 3), 12345, 6'b000000);
      step(3);
      for (int i = 0; i < 20; i++) begin
         x = int'($urandom_range(0, 65535));
         w = encode(x);
         send2(w, x, 6'b000000);
         step(3);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
